// File: rtl/regfile_write_queue_if.sv
// Writeback request handshake plus register-file write port, grouped for the write queue.
interface regfile_write_queue_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_valid, in_rd, in_data, wr_stall,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_rd, in_data, wr_stall,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Buffers register-file writebacks in a small FIFO, drains one per cycle to the single
// write port, and bypasses pending values to two read ports.
module regfile_write_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     RESET,
  regfile_write_queue_if.slave     bus,
  input  logic [ADDR_W-1:0]        rs1,
  input  logic [ADDR_W-1:0]        rs2,
  output logic                     byp1_hit,
  output logic [DATA_W-1:0]        byp1_data,
  output logic                     byp2_hit,
  output logic [DATA_W-1:0]        byp2_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic              enq, deq;
  logic              not_empty;

  assign not_empty    = (count != '0);
  assign bus.in_ready = (count != CNT_W'(DEPTH));
  assign bus.wr_en    = not_empty && !bus.wr_stall;
  assign bus.wr_addr  = not_empty ? mem_rd[head]   : '0;
  assign bus.wr_data  = not_empty ? mem_data[head] : '0;

  // x0 writes complete the handshake but never occupy a slot
  assign enq = bus.in_valid && bus.in_ready && (bus.in_rd != '0);
  assign deq = bus.wr_en;

  always_ff @(posedge clk) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[tail]   <= bus.in_rd;
      mem_data[tail] <= bus.in_data;
    end
  end

  // Walk from oldest to youngest so a later match overrides an earlier one
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((rs1 != '0) && (mem_rd[idx] == rs1)) begin
          byp1_hit  = 1'b1;
          byp1_data = mem_data[idx];
        end
        if ((rs2 != '0) && (mem_rd[idx] == rs2)) begin
          byp2_hit  = 1'b1;
          byp2_data = mem_data[idx];
        end
      end
    end
  end

  count_bound_a: assert property (@(posedge clk) disable iff (RESET) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: latency, full/stall, bypass, x0, wrap, reset.
module tb_regfile_write_queue;
  logic        clk = 1'b0;
  logic        RESET;
  logic [4:0]  rs1, rs2;
  logic        byp1_hit, byp2_hit;
  logic [63:0] byp1_data, byp2_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [68:0] commits [$];
  logic [68:0] exp_q   [$];
  logic [68:0] item;

  always #5 clk = ~clk;

  regfile_write_queue_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_write_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(4)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .bus       (bus),
    .rs1       (rs1),
    .rs2       (rs2),
    .byp1_hit  (byp1_hit),
    .byp1_data (byp1_data),
    .byp2_hit  (byp2_hit),
    .byp2_data (byp2_data),
    .count     (count)
  );

  // Register-file model: records every write captured at a clock edge
  always @(posedge clk) begin
    if (!RESET && bus.wr_en) commits.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_req(input logic [4:0] rd, input logic [63:0] data);
    bus.in_valid = 1'b1;
    bus.in_rd    = rd;
    bus.in_data  = data;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic [63:0] data);
    chk("commit_avail", 64'(commits.size() > 0), 64'd1);
    if (commits.size() > 0) begin
      item = commits.pop_front();
      chk("commit_addr", 64'(item[68:64]), 64'(rd));
      chk("commit_data", item[63:0], data);
    end
  endtask

  initial begin
    RESET        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rd    = '0;
    bus.in_data  = '0;
    bus.wr_stall = 1'b0;
    rs1          = '0;
    rs2          = '0;
    repeat (2) cyc();
    chk("rst_count",    64'(count),        64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wr_en",    64'(bus.wr_en),    64'd0);
    chk("rst_byp1",     64'(byp1_hit),     64'd0);
    RESET = 1'b0;
    cyc();

    // Single request: visible next cycle, committed one edge later
    push_req(5'd5, 64'hAAAA);
    chk("lat_wr_en",   64'(bus.wr_en),   64'd1);
    chk("lat_wr_addr", 64'(bus.wr_addr), 64'd5);
    chk("lat_wr_data", bus.wr_data,      64'hAAAA);
    chk("lat_count",   64'(count),       64'd1);
    cyc();
    chk("lat_count0",  64'(count),       64'd0);
    chk("lat_wr_en0",  64'(bus.wr_en),   64'd0);
    chk("lat_wr_addr0", 64'(bus.wr_addr), 64'd0);
    expect_commit(5'd5, 64'hAAAA);
    chk("lat_no_extra", 64'(commits.size()), 64'd0);

    // Fill under stall, hold a fifth request, then release
    bus.wr_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_req(5'(i), 64'(i * 'h11));
    chk("full_count",    64'(count),        64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_wr_en",    64'(bus.wr_en),    64'd0);
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd6;
    bus.in_data  = 64'h66;
    repeat (3) begin
      cyc();
      chk("hold_count",    64'(count),        64'd4);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("hold_no_commit", 64'(commits.size()), 64'd0);
    bus.wr_stall = 1'b0;
    cyc();
    chk("rel1_count",    64'(count),        64'd3);
    chk("rel1_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("rel2_count", 64'(count), 64'd3);
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    chk("rel_drained", 64'(count), 64'd0);
    expect_commit(5'd1, 64'h11);
    expect_commit(5'd2, 64'h22);
    expect_commit(5'd3, 64'h33);
    expect_commit(5'd4, 64'h44);
    expect_commit(5'd6, 64'h66);
    chk("rel_no_extra", 64'(commits.size()), 64'd0);

    // Bypass: youngest of two same-rd entries wins
    bus.wr_stall = 1'b1;
    push_req(5'd7, 64'h10);
    push_req(5'd7, 64'h20);
    rs1 = 5'd7;
    rs2 = 5'd8;
    #1;
    chk("byp_hit1",  64'(byp1_hit), 64'd1);
    chk("byp_data1", byp1_data,     64'h20);
    chk("byp_hit2",  64'(byp2_hit), 64'd0);
    chk("byp_data2", byp2_data,     64'd0);
    bus.wr_stall = 1'b0;
    cyc();
    chk("byp_head_hit",  64'(byp1_hit), 64'd1);
    chk("byp_head_data", byp1_data,     64'h20);
    cyc();
    chk("byp_gone", 64'(byp1_hit), 64'd0);
    expect_commit(5'd7, 64'h10);
    expect_commit(5'd7, 64'h20);

    // x0 request: accepted, never queued or written
    rs1 = '0;
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd0;
    bus.in_data  = 64'hFFFF;
    #1;
    chk("x0_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("x0_count", 64'(count),     64'd0);
    chk("x0_wr_en", 64'(bus.wr_en), 64'd0);
    chk("x0_byp",   64'(byp1_hit),  64'd0);
    cyc();
    chk("x0_wr_en2",  64'(bus.wr_en), 64'd0);
    chk("x0_no_write", 64'(commits.size()), 64'd0);

    // Steady state at 3 entries with continuous enqueue; pointers wrap repeatedly
    exp_q.delete();
    bus.wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_req(5'(10 + i), 64'('h100 + i));
      exp_q.push_back({5'(10 + i), 64'('h100 + i)});
    end
    chk("wrap_prefill", 64'(count), 64'd3);
    bus.wr_stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_rd    = 5'(i + 1);
      bus.in_data  = 64'('h1000 + i);
      exp_q.push_back({5'(i + 1), 64'('h1000 + i)});
      cyc();
      rs1 = 5'(i + 1);
      #1;
      chk("wrap_count", 64'(count), 64'd3);
      if (i % 5 == 4) begin
        chk("wrap_byp_hit",  64'(byp1_hit), 64'd1);
        chk("wrap_byp_data", byp1_data,     64'('h1000 + i));
      end
    end
    bus.in_valid = 1'b0;
    rs1 = '0;
    repeat (3) cyc();
    chk("wrap_drained", 64'(count), 64'd0);
    chk("wrap_n_commits", 64'(commits.size()), 64'd23);
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      expect_commit(item[68:64], item[63:0]);
    end

    // Reset with three pending entries discards them
    bus.wr_stall = 1'b1;
    push_req(5'd20, 64'h200);
    push_req(5'd21, 64'h201);
    push_req(5'd22, 64'h202);
    chk("rst3_count_pre", 64'(count), 64'd3);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    bus.wr_stall = 1'b0;
    rs1 = 5'd20;
    rs2 = 5'd22;
    #1;
    chk("rst3_count",    64'(count),        64'd0);
    chk("rst3_wr_en",    64'(bus.wr_en),    64'd0);
    chk("rst3_byp1",     64'(byp1_hit),     64'd0);
    chk("rst3_byp2",     64'(byp2_hit),     64'd0);
    chk("rst3_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) cyc();
    chk("rst3_no_write", 64'(commits.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
